// File: rtl/power_management_controller_if.sv
// Status, request and power-control signals between the power controller and its cores/CMU.
// The slave modport is the controller; the master modport is the surrounding SoC or bench.
interface power_management_controller_if;
    logic       pll_locked;
    logic       clocks_stable;
    logic       sleep_req_rt;
    logic       sleep_req_gp;
    logic       sleep_ack_rt;
    logic       sleep_ack_gp;
    logic [7:0] wake_irq;
    logic [7:0] wake_mask;
    logic       periph_activity;
    logic       power_down_rt;
    logic       power_down_gp;
    logic       power_down_periph;
    logic [1:0] rt_state;
    logic [1:0] gp_state;
    logic [7:0] wake_cause;
    logic       wake_done_rt;
    logic       wake_done_gp;

    modport master (
        output pll_locked, clocks_stable, sleep_req_rt, sleep_req_gp,
               wake_irq, wake_mask, periph_activity,
        input  sleep_ack_rt, sleep_ack_gp, power_down_rt, power_down_gp,
               power_down_periph, rt_state, gp_state, wake_cause,
               wake_done_rt, wake_done_gp
    );

    modport slave (
        input  pll_locked, clocks_stable, sleep_req_rt, sleep_req_gp,
               wake_irq, wake_mask, periph_activity,
        output sleep_ack_rt, sleep_ack_gp, power_down_rt, power_down_gp,
               power_down_periph, rt_state, gp_state, wake_cause,
               wake_done_rt, wake_done_gp
    );
endinterface

// File: rtl/power_management_controller.sv
// Sleep/wake sequencer for RT and GP cores plus idle-timed peripheral power-down.
// Sleep ACK one cycle after the request edge, OFF the next; no backpressure, all outputs registered.
module power_management_controller #(
    parameter int unsigned WAKE_SETTLE  = 16,
    parameter int unsigned IDLE_TIMEOUT = 1000
) (
    input logic                          clk_periph_25mhz,
    input logic                          rst_periph,
    power_management_controller_if.slave pm
);
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_ACK  = 2'd1,
        ST_OFF  = 2'd2,
        ST_WAKE = 2'd3
    } core_st_e;

    localparam logic [7:0]  SETTLE_INIT = 8'(WAKE_SETTLE - 1);
    localparam logic [15:0] IDLE_LAST   = 16'(IDLE_TIMEOUT - 1);

    // Index 0 is the RT core, index 1 the GP core.
    core_st_e    st_q [2];
    core_st_e    st_d [2];
    logic [7:0]  settle_q [2];
    logic [7:0]  settle_d [2];
    logic [1:0]  pend_q, pend_d, pend_now;
    logic [1:0]  req_prev_q, req;
    logic [1:0]  done_q, done_d;
    logic [15:0] idle_q, idle_d;
    logic        pd_periph_q, pd_periph_d;
    logic [7:0]  cause_q, cause_d;
    logic        wake_any, to_wake, all_off_q, all_off_d;

    always_comb begin
        wake_any = |(pm.wake_irq & pm.wake_mask);
        req      = {pm.sleep_req_gp, pm.sleep_req_rt};
        to_wake  = 1'b0;
        pend_now = pend_q | (req & ~req_prev_q);
        pend_d   = pend_now;
        done_d   = 2'b00;
        for (int c = 0; c < 2; c++) begin
            st_d[c]     = st_q[c];
            settle_d[c] = settle_q[c];
            case (st_q[c])
                ST_RUN: begin
                    if (pend_now[c] && pm.clocks_stable && pm.pll_locked && !wake_any) begin
                        st_d[c]   = ST_ACK;
                        pend_d[c] = 1'b0;
                    end
                end
                ST_ACK: st_d[c] = ST_OFF;
                ST_OFF: begin
                    if (wake_any || !pm.pll_locked) begin
                        st_d[c]     = ST_WAKE;
                        settle_d[c] = SETTLE_INIT;
                        to_wake     = 1'b1;
                    end
                end
                default: begin
                    if (settle_q[c] == 8'd0 && pm.clocks_stable) begin
                        st_d[c]   = ST_RUN;
                        done_d[c] = 1'b1;
                    end else if (settle_q[c] != 8'd0) begin
                        settle_d[c] = settle_q[c] - 8'd1;
                    end
                end
            endcase
        end

        cause_d   = to_wake ? (pm.wake_irq & pm.wake_mask) : cause_q;
        all_off_q = (st_q[0] == ST_OFF) && (st_q[1] == ST_OFF);
        all_off_d = (st_d[0] == ST_OFF) && (st_d[1] == ST_OFF);

        // Clearing looks at next state so the peripheral domain powers up
        // on the same edge the waking core leaves OFF.
        idle_d      = 16'd0;
        pd_periph_d = pd_periph_q;
        if (!all_off_d || pm.periph_activity) begin
            pd_periph_d = 1'b0;
        end else if (all_off_q && !pd_periph_q) begin
            if (idle_q == IDLE_LAST) pd_periph_d = 1'b1;
            else                     idle_d      = idle_q + 16'd1;
        end
    end

    always_ff @(posedge clk_periph_25mhz) begin
        if (rst_periph) begin
            for (int c = 0; c < 2; c++) begin
                st_q[c]     <= ST_RUN;
                settle_q[c] <= 8'd0;
            end
            pend_q      <= 2'b00;
            req_prev_q  <= 2'b00;
            done_q      <= 2'b00;
            idle_q      <= 16'd0;
            pd_periph_q <= 1'b0;
            cause_q     <= 8'd0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                st_q[c]     <= st_d[c];
                settle_q[c] <= settle_d[c];
            end
            pend_q      <= pend_d;
            req_prev_q  <= req;
            done_q      <= done_d;
            idle_q      <= idle_d;
            pd_periph_q <= pd_periph_d;
            cause_q     <= cause_d;
        end
    end

    assign pm.sleep_ack_rt      = (st_q[0] == ST_ACK);
    assign pm.sleep_ack_gp      = (st_q[1] == ST_ACK);
    assign pm.power_down_rt     = (st_q[0] == ST_OFF);
    assign pm.power_down_gp     = (st_q[1] == ST_OFF);
    assign pm.power_down_periph = pd_periph_q;
    assign pm.rt_state          = st_q[0];
    assign pm.gp_state          = st_q[1];
    assign pm.wake_cause        = cause_q;
    assign pm.wake_done_rt      = done_q[0];
    assign pm.wake_done_gp      = done_q[1];
endmodule

// File: tb/tb_power_management_controller.sv
// Directed bench for power_management_controller: reference model compared every cycle plus literal checks.
module tb_power_management_controller;
    localparam int WS = 16;
    localparam int IT = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #20 clk = ~clk;

    power_management_controller_if pm();

    power_management_controller #(.WAKE_SETTLE(WS), .IDLE_TIMEOUT(IT)) dut (
        .clk_periph_25mhz(clk),
        .rst_periph      (rst),
        .pm              (pm)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phases 0 run, 1 acknowledged, 2 off, 3 waking.
    int        m_st [2];
    int        m_el [2];
    bit        m_pend [2];
    bit        m_prev [2];
    bit        m_done [2];
    logic [7:0] m_cause;
    bit        m_pd;
    int        m_quiet;
    bit        m_init = 1'b0;

    always @(posedge clk) begin : model
        bit req [2];
        int nst [2];
        bit wa, woke;
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                m_st[c] = 0; m_el[c] = 0; m_pend[c] = 0; m_prev[c] = 0; m_done[c] = 0;
            end
            m_cause = 8'h00; m_pd = 0; m_quiet = 0; m_init = 1'b1;
        end else begin
            wa     = |(pm.wake_irq & pm.wake_mask);
            req[0] = pm.sleep_req_rt;
            req[1] = pm.sleep_req_gp;
            woke   = 0;
            for (int c = 0; c < 2; c++) begin
                if (req[c] && !m_prev[c]) m_pend[c] = 1;
                m_prev[c] = req[c];
                m_done[c] = 0;
                nst[c]    = m_st[c];
                if (m_st[c] == 0) begin
                    if (m_pend[c] && pm.clocks_stable && pm.pll_locked && !wa) begin
                        nst[c] = 1; m_pend[c] = 0;
                    end
                end else if (m_st[c] == 1) begin
                    nst[c] = 2;
                end else if (m_st[c] == 2) begin
                    if (wa || !pm.pll_locked) begin
                        nst[c] = 3; m_el[c] = 0; woke = 1;
                    end
                end else begin
                    if (m_el[c] + 1 >= WS && pm.clocks_stable) begin
                        nst[c] = 0; m_done[c] = 1;
                    end else begin
                        m_el[c]++;
                    end
                end
            end
            if (woke) m_cause = pm.wake_irq & pm.wake_mask;
            // Consecutive quiet cycles with both cores off; periph powers down after IT of them.
            if (m_st[0] == 2 && m_st[1] == 2 && !pm.periph_activity) m_quiet++;
            else m_quiet = 0;
            m_pd = (nst[0] == 2 && nst[1] == 2 && !pm.periph_activity) && (m_pd || m_quiet >= IT);
            m_st[0] = nst[0];
            m_st[1] = nst[1];
        end
    end

    function automatic logic [18:0] dut_vec();
        return {pm.sleep_ack_rt, pm.sleep_ack_gp, pm.power_down_rt, pm.power_down_gp,
                pm.power_down_periph, pm.rt_state, pm.gp_state, pm.wake_cause,
                pm.wake_done_rt, pm.wake_done_gp};
    endfunction

    function automatic logic [18:0] exp_vec();
        return {m_st[0] == 1, m_st[1] == 1, m_st[0] == 2, m_st[1] == 2, m_pd,
                2'(m_st[0]), 2'(m_st[1]), m_cause, m_done[0], m_done[1]};
    endfunction

    always @(negedge clk) begin
        if (m_init) chk("model_outputs", 32'(dut_vec()), 32'(exp_vec()));
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        pm.pll_locked = 1; pm.clocks_stable = 1;
        pm.sleep_req_rt = 0; pm.sleep_req_gp = 0;
        pm.wake_irq = 8'h00; pm.wake_mask = 8'h00; pm.periph_activity = 0;
        step(3);
        chk("reset_outputs", 32'(dut_vec()), 32'h0);
        rst = 0;
        step(5);

        // Sleep entry on RT
        pm.sleep_req_rt = 1;
        step();
        chk("rt_ack_pulse", {30'd0, pm.sleep_ack_rt, pm.sleep_ack_gp}, 32'h2);
        chk("rt_state_ack", 32'(pm.rt_state), 32'd1);
        step();
        chk("rt_ack_gone", 32'(pm.sleep_ack_rt), 32'd0);
        chk("rt_power_down", 32'(pm.power_down_rt), 32'd1);
        chk("rt_state_off", 32'(pm.rt_state), 32'd2);
        chk("gp_still_run", 32'(pm.gp_state), 32'd0);

        // Masked wake
        pm.wake_mask = 8'h04; pm.wake_irq = 8'h01;
        step(3);
        chk("masked_no_wake", 32'(pm.rt_state), 32'd2);
        pm.wake_irq = 8'h05;
        step();
        chk("rt_wake_state", 32'(pm.rt_state), 32'd3);
        chk("rt_wake_pd_low", 32'(pm.power_down_rt), 32'd0);
        chk("wake_cause_04", 32'(pm.wake_cause), 32'h04);
        pm.wake_irq = 8'h00;
        step(15);
        chk("settle_not_done", {30'd0, pm.rt_state}, 32'd3);
        step();
        chk("wake_done_rt_16", {30'd0, pm.wake_done_rt, pm.rt_state == 2'd0}, 32'h3);
        step();
        chk("wake_done_pulse", 32'(pm.wake_done_rt), 32'd0);

        // Settle blocked by clocks_stable
        pm.sleep_req_rt = 0; step(); pm.sleep_req_rt = 1; step(2);
        chk("rt_off_again", 32'(pm.rt_state), 32'd2);
        pm.clocks_stable = 0; pm.wake_irq = 8'h04;
        step();
        pm.wake_irq = 8'h00;
        step(20);
        chk("wake_held_unstable", 32'(pm.rt_state), 32'd3);
        pm.clocks_stable = 1;
        step();
        chk("run_after_stable", {30'd0, pm.wake_done_rt, pm.rt_state == 2'd0}, 32'h3);

        // Peripheral idle timeout with an activity restart, then dual wake
        pm.sleep_req_rt = 0; step();
        pm.sleep_req_rt = 1; pm.sleep_req_gp = 1;
        step(2);
        chk("both_off", {28'd0, pm.rt_state, pm.gp_state}, 32'hA);
        step(10);
        pm.periph_activity = 1; step(); pm.periph_activity = 0;
        step(19);
        chk("periph_not_yet", 32'(pm.power_down_periph), 32'd0);
        step();
        chk("periph_down", 32'(pm.power_down_periph), 32'd1);
        pm.wake_mask = 8'h05; pm.wake_irq = 8'h01;
        step();
        chk("periph_up_on_wake", 32'(pm.power_down_periph), 32'd0);
        chk("both_wake", {28'd0, pm.rt_state, pm.gp_state}, 32'hF);
        chk("wake_cause_01", 32'(pm.wake_cause), 32'h01);
        pm.wake_irq = 8'h00;
        step(16);
        chk("both_done", {30'd0, pm.wake_done_rt, pm.wake_done_gp}, 32'h3);

        // Sleep request held pending while a wake source is active
        pm.sleep_req_gp = 0; pm.wake_irq = 8'h01;
        step();
        pm.sleep_req_gp = 1;
        step();
        chk("gp_blocked", {30'd0, pm.gp_state}, 32'd0);
        step(3);
        chk("gp_still_blocked", 32'(pm.sleep_ack_gp), 32'd0);
        pm.wake_irq = 8'h00;
        step();
        chk("gp_ack_after_clear", 32'(pm.sleep_ack_gp), 32'd1);
        step();
        chk("gp_off", 32'(pm.gp_state), 32'd2);
        pm.pll_locked = 0;
        step();
        chk("gp_lockloss_wake", 32'(pm.gp_state), 32'd3);
        chk("lockloss_cause", 32'(pm.wake_cause), 32'h00);
        pm.pll_locked = 1;
        step(16);
        chk("gp_run_again", 32'(pm.gp_state), 32'd0);

        // Reset while both cores are off with requests held high
        pm.sleep_req_rt = 0; pm.sleep_req_gp = 0; step();
        pm.sleep_req_rt = 1; pm.sleep_req_gp = 1; step(2);
        chk("both_off_pre_rst", {28'd0, pm.rt_state, pm.gp_state}, 32'hA);
        rst = 1;
        step();
        chk("mid_reset_outputs", 32'(dut_vec()), 32'h0);
        step(2);
        rst = 0;
        step();
        chk("fresh_ack_both", {30'd0, pm.sleep_ack_rt, pm.sleep_ack_gp}, 32'h3);
        step(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
